// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one fpAdd core among NUM_REQ requesters.
// Only one operation is in flight at a time. A grant latches the winner's
// operands and then enables the core for LATENCY edges. After that, the
// core output is captured and a done pulse is sent to the winner.
// Optional build macro: FP_ARB_FIXED_PRIO_EN selects lowest-index-wins
// fixed priority. When it is not defined, arbitration is round-robin.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 7
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_add_sub,
  input  logic [32*NUM_REQ-1:0] req_dataa,
  input  logic [32*NUM_REQ-1:0] req_datab,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           result,
  output logic                  busy,
  output logic                  core_clk_en,
  output logic                  core_add_sub,
  output logic [31:0]           core_dataa,
  output logic [31:0]           core_datab,
  input  logic [31:0]           core_result
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   gnt_r;
  logic [IDX_W-1:0]   win_s;
  logic [31:0]        opa_s, opb_s;
  logic               op_s;
  logic [NUM_REQ-1:0] ack_r, done_r;
  logic [31:0]        result_r, core_dataa_r, core_datab_r;
  logic               core_clk_en_r, core_add_sub_r;

`ifdef FP_ARB_FIXED_PRIO_EN
  // Lowest set index wins. The loop runs downward, so the last hit is the lowest index.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] i_w;
    w = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      i_w = IDX_W'(i);
      if (r[i_w]) w = i_w;
    end
    return w;
  endfunction
`else
  logic [IDX_W-1:0] ptr_r;

  // Round-robin search starts at p+1 and wraps. The loop runs downward, so
  // the last hit is the nearest index after p.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] idx_w;
    w = p;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx_w = IDX_W'((int'(p) + k) % NUM_REQ);
      if (r[idx_w]) w = idx_w;
    end
    return w;
  endfunction
`endif

  // Winner selection and operand mux for the requester that wins this cycle.
  always_comb begin
`ifdef FP_ARB_FIXED_PRIO_EN
    win_s = pick_winner(req);
`else
    win_s = pick_winner(req, ptr_r);
`endif
    opa_s = 32'h0000_0000;
    opb_s = 32'h0000_0000;
    op_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      opa_s = (win_s == IDX_W'(i)) ? req_dataa[32*i +: 32] : opa_s;
      opb_s = (win_s == IDX_W'(i)) ? req_datab[32*i +: 32] : opb_s;
      op_s  = (win_s == IDX_W'(i)) ? req_add_sub[i]        : op_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) state_nxt_s = ST_RUN;
        else      state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) state_nxt_s = ST_RESP;
        else                   state_nxt_s = ST_RUN;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath updates: grant latching, the cycle counter, and result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r          <= '0;
      gnt_r          <= '0;
      ack_r          <= '0;
      done_r         <= '0;
      result_r       <= 32'h0000_0000;
      core_clk_en_r  <= 1'b0;
      core_add_sub_r <= 1'b0;
      core_dataa_r   <= 32'h0000_0000;
      core_datab_r   <= 32'h0000_0000;
`ifndef FP_ARB_FIXED_PRIO_EN
      ptr_r          <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      ack_r  <= '0;
      done_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            gnt_r          <= win_s;
            ack_r          <= ONE_HOT0 << win_s;
            core_dataa_r   <= opa_s;
            core_datab_r   <= opb_s;
            core_add_sub_r <= op_s;
            core_clk_en_r  <= 1'b1;
            cnt_r          <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
            ptr_r          <= win_s;
`endif
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r         <= '0;
            core_clk_en_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          result_r <= core_result;
          done_r   <= ONE_HOT0 << gnt_r;
        end
        default: begin
          core_clk_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign ack          = ack_r;
  assign done         = done_r;
  assign result       = result_r;
  assign busy         = (state_r != ST_IDLE);
  assign core_clk_en  = core_clk_en_r;
  assign core_add_sub = core_add_sub_r;
  assign core_dataa   = core_dataa_r;
  assign core_datab   = core_datab_r;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a scoreboard plus a forked monitor, driving a small fpAdd stand-in.
module tb_fp_add_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 7;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req, req_add_sub, ack, done;
  logic [32*NR-1:0] req_dataa, req_datab;
  logic [31:0]     result, core_dataa, core_datab, core_result;
  logic            busy, core_clk_en, core_add_sub;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct { int idx; int cyc; } ack_e_t;
  typedef struct { int idx; logic [31:0] res; } res_e_t;
  ack_e_t ack_q[$];
  res_e_t exp_q[$];

  bit [31:0] pipe [LAT];

  fp_add_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_add_sub(req_add_sub),
    .req_dataa(req_dataa), .req_datab(req_datab), .ack(ack), .done(done),
    .result(result), .busy(busy), .core_clk_en(core_clk_en),
    .core_add_sub(core_add_sub), .core_dataa(core_dataa),
    .core_datab(core_datab), .core_result(core_result)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Hand-computed IEEE-754 sums for the operand pairs that this bench uses.
  function automatic logic [31:0] fp_table(input logic op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {1'b1, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
      {1'b0, 32'h40400000, 32'h3F800000}: return 32'h40000000; // 3-1=2
      {1'b1, 32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
      {1'b1, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
      {1'b1, 32'h40000000, 32'h40800000}: return 32'h40C00000; // 2+4=6
      {1'b1, 32'h40800000, 32'h40800000}: return 32'h41000000; // 4+4=8
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // fpAdd stand-in: a LAT-deep pipeline that advances only when clk_en is high.
  always @(posedge clock) begin
    if (core_clk_en) begin
      pipe[0] <= fp_table(core_add_sub, core_dataa, core_datab);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign core_result = pipe[LAT-1];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] need);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, need, cyc);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] need);
    check(act === need, name, act, need);
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows ack or done.
  task automatic run_monitor();
    int last_ack = -100;
    int en_run = 0;
    logic [NR-1:0] prev_ack = '0;
    logic [NR-1:0] prev_done = '0;
    logic [31:0] last_res = 32'h0;
    ack_e_t ae;
    res_e_t re;
    int ai;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        check_eq("reset_outputs",
                 {ack, done, busy, core_clk_en, core_add_sub, 22'h0} | result | core_dataa | core_datab,
                 32'h0);
        en_run = 0; prev_ack = '0; prev_done = '0; last_res = 32'h0;
      end else begin
        if (ack != '0) begin
          check($onehot(ack), "ack_onehot", 32'(ack), 32'h0);
          check(prev_ack == '0, "ack_two_cycles", 32'(prev_ack), 32'h0);
          check_eq("ack_busy", 32'(busy), 32'h1);
          ai = 0;
          for (int i = 0; i < NR; i++) if (ack[i]) ai = i;
          check(ack_q.size() != 0, "ack_expected", 32'(ack), 32'h0);
          if (ack_q.size() != 0) begin
            ae = ack_q.pop_front();
            check_eq("ack_index", ai, ae.idx);
            check_eq("ack_cycle", cyc, ae.cyc);
          end
          last_ack = cyc;
          en_run = 0;
        end
        if (core_clk_en) en_run++;
        if (done != '0) begin
          check(prev_done == '0, "done_two_cycles", 32'(prev_done), 32'h0);
          check_eq("done_busy", 32'(busy), 32'h0);
          check(exp_q.size() != 0, "done_expected", 32'(done), 32'h0);
          if (exp_q.size() != 0) begin
            re = exp_q.pop_front();
            check_eq("done_index", 32'(done), 32'(1 << re.idx));
            check_eq("done_result", result, re.res);
          end
          check_eq("done_latency", cyc - last_ack, LAT + 1);
          check_eq("clk_en_cycles", en_run, LAT);
          last_res = result;
        end else begin
          check_eq("result_hold", result, last_res);
        end
        prev_ack = ack;
        prev_done = done;
      end
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_dataa[32*i +: 32] = a;
    req_datab[32*i +: 32] = b;
    req_add_sub[i] = op;
  endtask

  task automatic push(input int i, input int ack_cyc, input logic [31:0] res, input bit has_done);
    ack_e_t ae;
    res_e_t re;
    ae.idx = i; ae.cyc = ack_cyc;
    ack_q.push_back(ae);
    if (has_done) begin
      re.idx = i; re.res = res;
      exp_q.push_back(re);
    end
  endtask

  task automatic wait_ack(input int i);
    bit seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(posedge clock); #1;
      seen = ack[i];
    end
    check(seen, "ack_wait", 32'(seen), 32'h1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || ack_q.size() != 0); n++) @(posedge clock);
    check_eq("drain", exp_q.size() + ack_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    req = '0; req_add_sub = '0; req_dataa = '0; req_datab = '0;
    fork run_monitor(); join_none
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: req[2] alone, 1.0 + 2.0
    set_op(2, 32'h3F800000, 32'h40000000, 1'b1);
    t = cyc; push(2, t + 1, 32'h40400000, 1'b1);
    req[2] = 1'b1;
    wait_ack(2); req[2] = 1'b0;
    wait_drain();

    // 2: req[1] alone, 3.0 - 1.0
    set_op(1, 32'h40400000, 32'h3F800000, 1'b0);
    t = cyc; push(1, t + 1, 32'h40000000, 1'b1);
    req[1] = 1'b1;
    wait_ack(1); req[1] = 1'b0;
    wait_drain();

    // 3: req[0] and req[3] together from reset pointer
    pulse_reset();
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b1);
    set_op(3, 32'h40000000, 32'h40800000, 1'b1);
    t = cyc;
    push(0, t + 1, 32'h40000000, 1'b1);
    push(3, t + 10, 32'h40C00000, 1'b1);
    req[0] = 1'b1; req[3] = 1'b1;
    wait_ack(0); req[0] = 1'b0;
    wait_ack(3); req[3] = 1'b0;
    wait_drain();

    // 4: all requesters held; pointer is 3, so order starts at 0
    set_op(1, 32'h40000000, 32'h40000000, 1'b1);
    set_op(2, 32'h3F800000, 32'h40000000, 1'b1);
    t = cyc;
    for (int k = 0; k < 6; k++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      push(0, t + 1 + 9*k, 32'h40000000, 1'b1);
`else
      case (k % 4)
        0: push(0, t + 1 + 9*k, 32'h40000000, 1'b1);
        1: push(1, t + 1 + 9*k, 32'h40800000, 1'b1);
        2: push(2, t + 1 + 9*k, 32'h40400000, 1'b1);
        default: push(3, t + 1 + 9*k, 32'h40C00000, 1'b1);
      endcase
`endif
    end
    req = '1;
    for (int k = 0; k < 6; k++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
      wait_ack(0);
`else
      wait_ack(k % 4);
`endif
    end
    req = '0;
    wait_drain();

    // 5: reset at cnt=3 of RUN; the dropped op must produce no done
    t = cyc; push(0, t + 1, 32'h0, 1'b0);
    req[0] = 1'b1;
    wait_ack(0); req[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("run_clk_en", 32'(core_clk_en), 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_clk_en", 32'(core_clk_en), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_dataa", core_dataa, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    set_op(1, 32'h40800000, 32'h40800000, 1'b1);
    t = cyc; push(1, t + 1, 32'h41000000, 1'b1);
    req[1] = 1'b1;
    wait_ack(1); req[1] = 1'b0;
    wait_drain();

`ifdef FP_ARB_FIXED_PRIO_EN
    // 6: req[0] and req[2] held; only 0 wins until it drops
    t = cyc;
    for (int k = 0; k < 3; k++) push(0, t + 1 + 9*k, 32'h40000000, 1'b1);
    push(2, t + 28, 32'h40400000, 1'b1);
    req[0] = 1'b1; req[2] = 1'b1;
    for (int k = 0; k < 3; k++) wait_ack(0);
    req[0] = 1'b0;
    wait_ack(2); req[2] = 1'b0;
    wait_drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
